// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: TUSE/TNEW encodings, MD latencies, MD FSM states.
package pipe_pkg;

  // Cycles until an operand is consumed in ID; TUSE_NONE marks an unused operand.
  localparam logic [1:0] TUSE_0    = 2'd0;
  localparam logic [1:0] TUSE_1    = 2'd1;
  localparam logic [1:0] TUSE_2    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Cycles until a result becomes forwardable, already adjusted for the producing stage.
  localparam logic [1:0] TNEW_0 = 2'd0;
  localparam logic [1:0] TNEW_1 = 2'd1;
  localparam logic [1:0] TNEW_2 = 2'd2;
  localparam logic [1:0] TNEW_3 = 2'd3;

  // Default busy durations of the multiply/divide unit.
  localparam int unsigned DEF_MULT_CYCLES = 5;
  localparam int unsigned DEF_DIV_CYCLES  = 10;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_busy_timer.sv
// Multiply/divide busy timer: tracks how long HI/LO remain unavailable after an EX-stage start.
module md_busy_timer
  import pipe_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  input  logic kill,
  output logic busy
);

  localparam int unsigned MaxCycles = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  md_state_e       state_q;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] load_val;
  logic            do_start;

  // A start in a flushed EX slot never reaches the MD unit.
  assign do_start = start & ~kill;
  assign load_val = is_div ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);

  // Timer FSM: a start (re)loads the counter; BUSY counts down and leaves as it hits zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else if (do_start) begin
      state_q <= StBusy;
      cnt_q   <= load_val;
    end else if (state_q == StBusy) begin
      cnt_q <= cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) begin
        state_q <= StIdle;
      end
    end
  end

  assign busy = (state_q == StBusy);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: ID-stage hazard detection, MD busy timing, stall statistics.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs_addr,
  input  logic [4:0]  D_rt_addr,
  input  logic [1:0]  D_rs_tuse,
  input  logic [1:0]  D_rt_tuse,
  input  logic        D_is_md,
  input  logic        D_is_eret,
  input  logic [4:0]  E_wa,
  input  logic [4:0]  M_wa,
  input  logic [1:0]  E_tnew,
  input  logic [1:0]  M_tnew,
  input  logic        E_md_start,
  input  logic        E_md_is_div,
  input  logic        E_mtc0_epc,
  input  logic        M_mtc0_epc,
  input  logic        int_req,
  output logic        stall,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_bubble,
  output logic        flush_req,
  output logic        md_busy,
  output logic [31:0] stall_cycles
);

  logic        rs_hazard;
  logic        rt_hazard;
  logic        md_hazard;
  logic        epc_hazard;
  logic [31:0] stall_cycles_q;

  md_busy_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (E_md_start),
    .is_div (E_md_is_div),
    .kill   (int_req),
    .busy   (md_busy)
  );

  // Operand hazards: a pending producer whose result arrives later than the operand is needed.
  // $zero is never a hazard, which also masks the "no write" encoding of E_wa/M_wa.
  always_comb begin
    rs_hazard = (D_rs_addr != 5'd0) &&
                (((D_rs_addr == E_wa) && (E_tnew > D_rs_tuse)) ||
                 ((D_rs_addr == M_wa) && (M_tnew > D_rs_tuse)));
    rt_hazard = (D_rt_addr != 5'd0) &&
                (((D_rt_addr == E_wa) && (E_tnew > D_rt_tuse)) ||
                 ((D_rt_addr == M_wa) && (M_tnew > D_rt_tuse)));
    md_hazard  = D_is_md && (md_busy || E_md_start);
    epc_hazard = D_is_eret && (E_mtc0_epc || M_mtc0_epc);
  end

  // Flush wins over stall so the PC is free to load the handler address.
  always_comb begin
    stall        = (rs_hazard || rt_hazard || md_hazard || epc_hazard) && !int_req;
    pc_en        = ~stall;
    if_id_en     = ~stall;
    id_ex_bubble = stall;
    flush_req    = int_req;
  end

  // Saturating count of cycles spent stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= '0;
    end else if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, directed corner sequences, random run.
module tb_pipe_hazard_ctrl;

  localparam int unsigned MultN = 5;
  localparam int unsigned DivN  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  D_rs_addr, D_rt_addr, E_wa, M_wa;
  logic [1:0]  D_rs_tuse, D_rt_tuse, E_tnew, M_tnew;
  logic        D_is_md, D_is_eret, E_md_start, E_md_is_div, E_mtc0_epc, M_mtc0_epc, int_req;
  logic        stall, pc_en, if_id_en, id_ex_bubble, flush_req, md_busy;
  logic [31:0] stall_cycles;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .MULT_CYCLES (MultN),
    .DIV_CYCLES  (DivN)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .D_rs_addr    (D_rs_addr),
    .D_rt_addr    (D_rt_addr),
    .D_rs_tuse    (D_rs_tuse),
    .D_rt_tuse    (D_rt_tuse),
    .D_is_md      (D_is_md),
    .D_is_eret    (D_is_eret),
    .E_wa         (E_wa),
    .M_wa         (M_wa),
    .E_tnew       (E_tnew),
    .M_tnew       (M_tnew),
    .E_md_start   (E_md_start),
    .E_md_is_div  (E_md_is_div),
    .E_mtc0_epc   (E_mtc0_epc),
    .M_mtc0_epc   (M_mtc0_epc),
    .int_req      (int_req),
    .stall        (stall),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .id_ex_bubble (id_ex_bubble),
    .flush_req    (flush_req),
    .md_busy      (md_busy),
    .stall_cycles (stall_cycles)
  );

  typedef struct {
    logic [4:0] rs, rt;
    logic [1:0] rs_tuse, rt_tuse;
    logic       is_md, is_eret;
    logic [4:0] e_wa, m_wa;
    logic [1:0] e_tnew, m_tnew;
    logic       md_start, e_epc, m_epc, irq;
    logic       exp_stall;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    D_rs_addr = 0; D_rt_addr = 0; D_rs_tuse = 2'd3; D_rt_tuse = 2'd3;
    D_is_md = 0; D_is_eret = 0; E_wa = 0; M_wa = 0; E_tnew = 0; M_tnew = 0;
    E_md_start = 0; E_md_is_div = 0; E_mtc0_epc = 0; M_mtc0_epc = 0; int_req = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
  endtask

  // Reference: rule-level hazard check for one source operand.
  function automatic bit op_hazard(input int addr, input int tuse, input int ewa, input int etn,
                                   input int mwa, input int mtn);
    if (addr == 0) return 0;
    return ((addr == ewa) && (etn > tuse)) || ((addr == mwa) && (mtn > tuse));
  endfunction

  // Reference state: remaining busy cycles of the MD unit and the stall tally.
  int          md_left;
  longint      stall_tally;

  initial begin
    bit exp_stall;
    int busy_seen;

    vecs[0]  = '{5'd8, 5'd0, 2'd1, 2'd3, 0, 0, 5'd8, 5'd0, 2'd2, 2'd0, 0, 0, 0, 0, 1};
    vecs[1]  = '{5'd8, 5'd0, 2'd2, 2'd3, 0, 0, 5'd8, 5'd0, 2'd2, 2'd0, 0, 0, 0, 0, 0};
    vecs[2]  = '{5'd0, 5'd0, 2'd0, 2'd0, 0, 0, 5'd0, 5'd0, 2'd2, 2'd2, 0, 0, 0, 0, 0};
    vecs[3]  = '{5'd0, 5'd9, 2'd3, 2'd0, 0, 0, 5'd0, 5'd9, 2'd0, 2'd1, 0, 0, 0, 0, 1};
    vecs[4]  = '{5'd0, 5'd9, 2'd3, 2'd1, 0, 0, 5'd0, 5'd9, 2'd0, 2'd1, 0, 0, 0, 0, 0};
    vecs[5]  = '{5'd0, 5'd5, 2'd3, 2'd3, 0, 0, 5'd5, 5'd0, 2'd3, 2'd0, 0, 0, 0, 0, 0};
    vecs[6]  = '{5'd0, 5'd5, 2'd3, 2'd2, 0, 0, 5'd5, 5'd0, 2'd3, 2'd0, 0, 0, 0, 0, 1};
    vecs[7]  = '{5'd0, 5'd0, 2'd3, 2'd3, 1, 0, 5'd0, 5'd0, 2'd0, 2'd0, 1, 0, 0, 0, 1};
    vecs[8]  = '{5'd0, 5'd0, 2'd3, 2'd3, 0, 0, 5'd0, 5'd0, 2'd0, 2'd0, 1, 0, 0, 0, 0};
    vecs[9]  = '{5'd0, 5'd0, 2'd3, 2'd3, 0, 1, 5'd0, 5'd0, 2'd0, 2'd0, 0, 1, 0, 0, 1};
    vecs[10] = '{5'd0, 5'd0, 2'd3, 2'd3, 0, 0, 5'd0, 5'd0, 2'd0, 2'd0, 0, 0, 1, 0, 0};
    vecs[11] = '{5'd0, 5'd0, 2'd3, 2'd3, 0, 1, 5'd0, 5'd0, 2'd0, 2'd0, 0, 0, 1, 1, 0};
    vecs[12] = '{5'd8, 5'd0, 2'd0, 2'd3, 0, 0, 5'd8, 5'd0, 2'd2, 2'd0, 0, 0, 0, 1, 0};
    vecs[13] = '{5'd8, 5'd0, 2'd0, 2'd3, 0, 0, 5'd7, 5'd0, 2'd2, 2'd0, 0, 0, 0, 0, 0};

    idle_inputs();
    reset = 1'b1;
    #2;
    chk("reset_md_busy", {31'd0, md_busy}, 32'd0);
    chk("reset_stall_cycles", stall_cycles, 32'd0);

    // Vector table, applied with reset held so the MD timer and counter stay cleared.
    foreach (vecs[i]) begin
      D_rs_addr = vecs[i].rs;     D_rt_addr = vecs[i].rt;
      D_rs_tuse = vecs[i].rs_tuse; D_rt_tuse = vecs[i].rt_tuse;
      D_is_md = vecs[i].is_md;    D_is_eret = vecs[i].is_eret;
      E_wa = vecs[i].e_wa;        M_wa = vecs[i].m_wa;
      E_tnew = vecs[i].e_tnew;    M_tnew = vecs[i].m_tnew;
      E_md_start = vecs[i].md_start; E_md_is_div = 1'b0;
      E_mtc0_epc = vecs[i].e_epc; M_mtc0_epc = vecs[i].m_epc;
      int_req = vecs[i].irq;
      step();
      chk($sformatf("vec%0d_stall", i), {31'd0, stall}, {31'd0, vecs[i].exp_stall});
      chk($sformatf("vec%0d_pc_en", i), {31'd0, pc_en}, {31'd0, ~vecs[i].exp_stall});
      chk($sformatf("vec%0d_if_id_en", i), {31'd0, if_id_en}, {31'd0, ~vecs[i].exp_stall});
      chk($sformatf("vec%0d_bubble", i), {31'd0, id_ex_bubble}, {31'd0, vecs[i].exp_stall});
      chk($sformatf("vec%0d_flush", i), {31'd0, flush_req}, {31'd0, vecs[i].irq});
      chk($sformatf("vec%0d_md_busy", i), {31'd0, md_busy}, 32'd0);
      chk($sformatf("vec%0d_stall_cycles", i), stall_cycles, 32'd0);
    end

    // Load-use: lw in EX, consumer in ID, then the load moves to MEM.
    idle_inputs();
    reset = 1'b0;
    step();
    D_rs_addr = 8; D_rs_tuse = 1; E_wa = 8; E_tnew = 2;
    #1;
    chk("loaduse_stall", {31'd0, stall}, 32'd1);
    step();
    E_wa = 0; E_tnew = 0; M_wa = 8; M_tnew = 1;
    #1;
    chk("loaduse_clear", {31'd0, stall}, 32'd0);
    chk("loaduse_count", stall_cycles, 32'd1);

    // mult start with mfhi waiting in ID.
    idle_inputs();
    pulse_reset();
    E_md_start = 1; E_md_is_div = 0; D_is_md = 1;
    #1;
    chk("mult_start_stall", {31'd0, stall}, 32'd1);
    chk("mult_start_busy", {31'd0, md_busy}, 32'd0);
    step();
    E_md_start = 0;
    busy_seen = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (md_busy) busy_seen++;
      if (c < 5) chk($sformatf("mult_busy_stall%0d", c), {31'd0, stall}, 32'd1);
      step();
    end
    chk("mult_busy_len", busy_seen, 32'd5);
    chk("mult_stall_cycles", stall_cycles, 32'd6);

    // div start then asynchronous reset mid-run.
    idle_inputs();
    pulse_reset();
    E_md_start = 1; E_md_is_div = 1; D_is_md = 1;
    step();
    E_md_start = 0;
    step();
    step();
    step();
    chk("div_busy_before_reset", {31'd0, md_busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("div_reset_async_busy", {31'd0, md_busy}, 32'd0);
    chk("div_reset_async_count", stall_cycles, 32'd0);
    step();
    reset = 1'b0;

    // Interrupt in the same cycle as an MD start and a data hazard.
    idle_inputs();
    step();
    int_req = 1; E_md_start = 1; D_is_md = 1; D_rs_addr = 3; D_rs_tuse = 0; E_wa = 3; E_tnew = 1;
    #1;
    chk("irq_flush", {31'd0, flush_req}, 32'd1);
    chk("irq_stall", {31'd0, stall}, 32'd0);
    step();
    idle_inputs();
    #1;
    chk("irq_no_busy", {31'd0, md_busy}, 32'd0);
    chk("irq_no_count", stall_cycles, 32'd0);

    // eret behind an mtc0 EPC in MEM, then the mtc0 retires.
    D_is_eret = 1; M_mtc0_epc = 1;
    #1;
    chk("eret_stall", {31'd0, stall}, 32'd1);
    step();
    M_mtc0_epc = 0;
    #1;
    chk("eret_clear", {31'd0, stall}, 32'd0);

    // Random run against the rule-level model.
    idle_inputs();
    pulse_reset();
    md_left = 0;
    stall_tally = 0;
    for (int n = 0; n < 2000; n++) begin
      D_rs_addr   = 5'($urandom_range(0, 3));
      D_rt_addr   = 5'($urandom_range(0, 3));
      D_rs_tuse   = 2'($urandom_range(0, 3));
      D_rt_tuse   = 2'($urandom_range(0, 3));
      E_wa        = 5'($urandom_range(0, 3));
      M_wa        = 5'($urandom_range(0, 3));
      E_tnew      = 2'($urandom_range(0, 3));
      M_tnew      = 2'($urandom_range(0, 3));
      D_is_md     = ($urandom_range(0, 2) == 0);
      D_is_eret   = ($urandom_range(0, 4) == 0);
      E_md_start  = ($urandom_range(0, 9) == 0);
      E_md_is_div = $urandom_range(0, 1) == 1;
      E_mtc0_epc  = ($urandom_range(0, 5) == 0);
      M_mtc0_epc  = ($urandom_range(0, 5) == 0);
      int_req     = ($urandom_range(0, 11) == 0);
      reset       = ($urandom_range(0, 63) == 0);
      #1;
      if (reset) begin
        md_left = 0;
        stall_tally = 0;
      end
      exp_stall = !int_req && (
        op_hazard(D_rs_addr, D_rs_tuse, E_wa, E_tnew, M_wa, M_tnew) ||
        op_hazard(D_rt_addr, D_rt_tuse, E_wa, E_tnew, M_wa, M_tnew) ||
        (D_is_md && (md_left > 0 || E_md_start)) ||
        (D_is_eret && (E_mtc0_epc || M_mtc0_epc)));
      chk($sformatf("rnd%0d_stall", n), {31'd0, stall}, {31'd0, exp_stall});
      chk($sformatf("rnd%0d_pc_en", n), {31'd0, pc_en}, {31'd0, !exp_stall});
      chk($sformatf("rnd%0d_bubble", n), {31'd0, id_ex_bubble}, {31'd0, exp_stall});
      chk($sformatf("rnd%0d_flush", n), {31'd0, flush_req}, {31'd0, int_req});
      chk($sformatf("rnd%0d_md_busy", n), {31'd0, md_busy}, {31'd0, md_left > 0});
      chk($sformatf("rnd%0d_count", n), stall_cycles, 32'(stall_tally));
      if (!reset) begin
        if (exp_stall && stall_tally < 64'hFFFF_FFFF) stall_tally++;
        if (E_md_start && !int_req) md_left = E_md_is_div ? DivN : MultN;
        else if (md_left > 0) md_left--;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
